// File: rtl/seq_addsub_64bit_if.sv
// Operand/result bus for seq_addsub_64bit: start handshake, operands,
// status and registered result. The overflow line only exists when
// ADDSUB_OVERFLOW_EN is defined.
interface seq_addsub_64bit_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef ADDSUB_OVERFLOW_EN
  logic             overflow;

  modport master (
    output start, sub, in1, in2, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, sub, in1, in2, c_in,
    output busy, done, sum, c_out, overflow
  );
`else
  modport master (
    output start, sub, in1, in2, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, sub, in1, in2, c_in,
    output busy, done, sum, c_out
  );
`endif
endinterface

// File: rtl/seq_addsub_64bit.sv
// Multi-cycle adder/subtractor. Operands are latched on an accepted start
// and consumed CHUNK bits per clock, LSB first, with the carry held in a
// register between chunks. Subtraction is done as A + ~B + !borrow_in, so
// the internal carry is the inverse of the borrow.
// Optional feature macro: ADDSUB_OVERFLOW_EN adds a registered signed
// overflow output.
module seq_addsub_64bit #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input logic              clk,
  input logic              rst_n,
  seq_addsub_64bit_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic                   carry_q;
  logic                   sub_q;
  logic [CW-1:0]          cnt_q;
  logic [WIDTH-CHUNK-1:0] res_q;
  logic [WIDTH-1:0]       sum_q;
  logic                   cout_q;
  logic [CHUNK:0]         chunk_res;
  logic [WIDTH-1:0]       res_full;
  logic                   accept;
  logic                   last_chunk;
`ifdef ADDSUB_OVERFLOW_EN
  logic                   ovf_q;
  logic                   msb_cin;
`endif

  // One chunk of the ripple: {carry_out, sum} = a + b + carry_in
  function automatic logic [CHUNK:0] chunk_add(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             c
  );
    chunk_add = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
  endfunction

  assign accept     = bus.start && (state_q != RUN);
  assign last_chunk = (state_q == RUN) && (cnt_q == CW'(N - 1));
  assign chunk_res  = chunk_add(a_q[CHUNK-1:0], b_q[CHUNK-1:0], carry_q);
  // Newest chunk on top of the previously produced ones; after the last
  // chunk this is the complete result.
  assign res_full   = {chunk_res[CHUNK-1:0], res_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch and per-chunk processing; operands shift right so the
  // active chunk is always in the low bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.in1;
      b_q     <= bus.sub ? ~bus.in2 : bus.in2;
      carry_q <= bus.sub ? ~bus.c_in : bus.c_in;
      sub_q   <= bus.sub;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> CHUNK;
      b_q     <= b_q >> CHUNK;
      carry_q <= chunk_res[CHUNK];
      res_q   <= res_full[WIDTH-1:CHUNK];
      cnt_q   <= cnt_q + CW'(1);
    end
  end

`ifdef ADDSUB_OVERFLOW_EN
  // Carry into the MSB recovered from the MSB's own sum bit
  assign msb_cin = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_res[CHUNK-1];
`endif

  // Result registers, updated only on the edge that finishes the last chunk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef ADDSUB_OVERFLOW_EN
      ovf_q  <= 1'b0;
`endif
    end else if (last_chunk) begin
      sum_q  <= res_full;
      cout_q <= chunk_res[CHUNK] ^ sub_q;
`ifdef ADDSUB_OVERFLOW_EN
      ovf_q  <= msb_cin ^ chunk_res[CHUNK];
`endif
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = cout_q;
`ifdef ADDSUB_OVERFLOW_EN
  assign bus.overflow = ovf_q;
`endif

endmodule

// File: doc/seq_addsub_64bit.md
# seq_addsub_64bit

Multi-cycle 64-bit adder/subtractor. It accepts operands under a start/done handshake and processes CHUNK bits per clock, LSB first, with a registered carry/borrow between chunks. It is the subtract-capable, sequential counterpart to the combinational ripple-carry adder, for datapaths that trade latency for a short carry chain per cycle.

## Interface

**Parameters**
- `WIDTH`, 64: operand and result width.
- `CHUNK`, 8: bits processed per cycle. Must divide `WIDTH`. `N = WIDTH/CHUNK`.

**Ports**
- `clk` input, 1: the single clock. All state changes on its rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: request a new operation. Sampled only when `busy`=0.
- `sub` input, 1: 0 selects add, 1 selects subtract. Latched on an accepted start.
- `in1` input, WIDTH: first operand. Latched on an accepted start.
- `in2` input, WIDTH: second operand. Latched on an accepted start.
- `c_in` input, 1: carry-in for add, borrow-in for subtract. Latched on an accepted start.
- `busy` output, 1: operation in progress.
- `done` output, 1: one-cycle pulse when the result is written.
- `sum` output, WIDTH: registered result. Holds its value until the next completion.
- `c_out` output, 1: carry-out for add, borrow-out for subtract. Registered with `sum`.
- `overflow` output, 1: signed overflow. Present only with `ADDSUB_OVERFLOW_EN`.

## Operation

**States**
- IDLE: the reset state. If `start`=1, go to RUN.
- RUN: go to DONE after chunk N-1 is processed.
- DONE: lasts one cycle. If `start`=1, go to RUN; otherwise go to IDLE.

**Accepted start (IDLE or DONE with `start`=1)**
- Latch A=`in1`.
- Latch B=`in2` for add, B=~`in2` for subtract.
- Carry register = `c_in` for add, = !`c_in` for subtract.
- Chunk counter = 0.

**Each RUN cycle**
- Add chunk k: `{c, s_k} = A[k] + B[k] + carry`.
- Store `s_k` in the result shift register and `c` in the carry register.
- Increment k.

**Completion (edge processing chunk N-1)**
- Load `sum` from the shift register.
- `c_out` = final carry for add, = !final carry for subtract.
- Assert `done` for the following cycle.

**Arithmetic rules**
- Add: `sum = (in1 + in2 + c_in) mod 2^WIDTH`; `c_out` = bit WIDTH of the unbounded sum.
- Subtract: `sum = (in1 - in2 - c_in) mod 2^WIDTH`; `c_out`=1 iff `in1 < in2 + c_in` (unsigned).

**Boundary conditions**
- `start` while `busy`=1: ignored. The current operation is not disturbed.
- Input changes after acceptance have no effect.
- `sum`/`c_out` keep the previous result throughout RUN and update only at completion.
- Reset asserted mid-RUN: immediate abort. State goes to IDLE, the partial result is discarded and all outputs go to 0.

## Timing

**Reset values**
- `busy`=0, `done`=0, `sum`=0, `c_out`=0, `overflow`=0.
- State IDLE; all internal registers 0.

**Cycle sequence**
- Start accepted at edge E0: `busy`=1 from E0.
- Chunks are processed at edges E1..EN.
- `done`=1 and the new `sum`/`c_out` are visible after EN.
- `busy`=0 in the DONE cycle.

**Latency**
- N cycles from the accepting edge to `done`. With default parameters this is 8 cycles.

**Throughput**
- Back-to-back operation: a start sampled in the DONE cycle is accepted.
- One result every N+1 cycles.

## Configuration

- `ADDSUB_OVERFLOW_EN` defined:
  - Adds output port `overflow`, registered with `sum`.
  - `overflow` = carry into the MSB XOR carry out of the MSB. This uses the internal carry, before the subtract inversion.
  - It is 1 when the two's-complement result is not representable.
- Undefined: the port, its register and the MSB carry tap are all absent. All other behaviour is identical.

## Test plan

- **Add, no carry-in.** `in1`=12345678912345, `in2`=98765432198765, `c_in`=0, `sub`=0 -> `sum`=111111111111110, `c_out`=0. `done` exactly 8 cycles after the accepting edge.
- **Add, with carry-in.** Same operands, `c_in`=1 -> `sum`=111111111111111, `c_out`=0.
- **Add, carry-out boundary.**
  - `in1`=18446744073709551610, `in2`=5, `c_in`=0 -> `sum`=2^64-1, `c_out`=0.
  - `in2`=6 -> `sum`=0, `c_out`=1.
  - `in2`=6, `c_in`=1 -> `sum`=1, `c_out`=1.
- **Subtract.**
  - `in1`=5, `in2`=6, `c_in`=0 -> `sum`=2^64-1, `c_out`=1.
  - `in1`=100, `in2`=58, `c_in`=1 -> `sum`=41, `c_out`=0.
  - With the macro: `in1`=2^63, `in2`=1, `sub`=1 -> `overflow`=1.
  - With the macro: `in1`=2^63-1, `in2`=1, add -> `overflow`=1.
- **Handshake.**
  - `start` pulsed at cycle 3 of RUN with new operands -> ignored; first result unchanged.
  - `sum` holds the prior result during RUN.
  - `start` held high through DONE -> second op accepted; its `done` follows 8 cycles later.
- **Reset mid-operation.** `rst_n` low at cycle 4 of RUN, asynchronously -> all outputs 0 immediately; no `done`. After release, a fresh add 1+1 -> `sum`=2 after 8 cycles.
